// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends a start bit, 8 data bits,
// odd parity and stop on device-generated clock falls, then checks the device ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       done,
    output logic       err
);

    localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] INH_PRE  = CNT_W'(INHIBIT_CYCLES - 2);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic             INH_ONE  = (INHIBIT_CYCLES == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_DATA,
        S_WAIT_IDLE
    } state_t;

    state_t           state_reg;
    logic [2:0]       clk_sync_reg;
    logic [1:0]       data_sync_reg;
    logic [7:0]       byte_reg;
    logic             parity_reg;
    logic [3:0]       bit_idx_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             ack_reg;
    logic             clk_oe_reg;
    logic             data_oe_reg;
    logic             done_reg;
    logic             err_reg;

    logic fall;
    logic clk_s;
    logic data_s;

    assign fall   = clk_sync_reg[2] & ~clk_sync_reg[1];
    assign clk_s  = clk_sync_reg[2];
    assign data_s = data_sync_reg[1];

    assign tx_ready    = (state_reg == S_IDLE);
    assign ps2_clk_oe  = clk_oe_reg;
    assign ps2_data_oe = data_oe_reg;
    assign done        = done_reg;
    assign err         = err_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= S_IDLE;
            clk_sync_reg  <= 3'b111;
            data_sync_reg <= 2'b11;
            byte_reg      <= '0;
            parity_reg    <= 1'b0;
            bit_idx_reg   <= '0;
            cnt_reg       <= '0;
            ack_reg       <= 1'b0;
            clk_oe_reg    <= 1'b0;
            data_oe_reg   <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[1:0], ps2_clk};
            data_sync_reg <= {data_sync_reg[0], ps2_data};
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;

            case (state_reg)
                S_IDLE: begin
                    if (tx_valid) begin
                        byte_reg    <= tx_data;
                        parity_reg  <= ~^tx_data;
                        cnt_reg     <= '0;
                        ack_reg     <= 1'b0;
                        clk_oe_reg  <= 1'b1;
                        data_oe_reg <= INH_ONE;
                        state_reg   <= S_INHIBIT;
                    end
                end

                S_INHIBIT: begin
                    if (cnt_reg == INH_LAST) begin
                        clk_oe_reg  <= 1'b0;
                        data_oe_reg <= 1'b1;
                        bit_idx_reg <= '0;
                        cnt_reg     <= '0;
                        state_reg   <= S_START;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                        // Data goes low one cycle before the clock is released.
                        if (cnt_reg == INH_PRE) begin
                            data_oe_reg <= 1'b1;
                        end
                    end
                end

                S_START, S_DATA: begin
                    if (cnt_reg == TMO_LAST) begin
                        clk_oe_reg  <= 1'b0;
                        data_oe_reg <= 1'b0;
                        ack_reg     <= 1'b0;
                        err_reg     <= 1'b1;
                        state_reg   <= S_WAIT_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                        if (fall) begin
                            // bit_idx_reg counts falls already seen in this frame.
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                            state_reg   <= S_DATA;
                            if (bit_idx_reg < 4'd8) begin
                                data_oe_reg <= ~byte_reg[bit_idx_reg[2:0]];
                            end else if (bit_idx_reg == 4'd8) begin
                                data_oe_reg <= ~parity_reg;
                            end else if (bit_idx_reg == 4'd9) begin
                                data_oe_reg <= 1'b0;
                            end else begin
                                ack_reg     <= ~data_s;
                                err_reg     <= data_s;
                                data_oe_reg <= 1'b0;
                                state_reg   <= S_WAIT_IDLE;
                            end
                        end
                    end
                end

                S_WAIT_IDLE: begin
                    if (clk_s && data_s) begin
                        done_reg  <= ack_reg;
                        state_reg <= S_IDLE;
                    end
                end

                default: begin
                    clk_oe_reg  <= 1'b0;
                    data_oe_reg <= 1'b0;
                    state_reg   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and a
// scoreboard holds the expected line bits and done/err pulse counts per request.
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TMO = 600;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       done;
    logic       err;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       clk_line;
    logic       data_line;

    assign clk_line  = dev_clk & ~ps2_clk_oe;
    assign data_line = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk    (clk_line),
        .ps2_data   (data_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int inh_cnt = 0;
    int inh_data_cnt = 0;

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (err) err_cnt <= err_cnt + 1;
        if (done && err) both_cnt <= both_cnt + 1;
        if (ps2_clk_oe) inh_cnt <= inh_cnt + 1;
        if (ps2_clk_oe && ps2_data_oe) inh_data_cnt <= inh_data_cnt + 1;
    end

    typedef struct {
        logic [10:0] bits;
        int          n_done;
        int          n_err;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Line image of a frame: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, (ones % 2 == 0), d, 1'b0};
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_ready) break;
        end
        check("return_idle", tx_ready, 1);
    endtask

    task automatic request(input logic [7:0] d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("ready_wait", tx_ready, 1);
            return;
        end
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic device_frame(input logic ack, input int abort_fall, input int inject_fall,
                                output logic [10:0] bits, output bit ok, output bit ready_seen);
        ok = 1'b0;
        ready_seen = 1'b0;
        bits = '0;
        for (int i = 0; i < INH + 100; i++) begin
            @(negedge clk);
            if (!ps2_clk_oe && ps2_data_oe) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("rts_wait", {ps2_clk_oe, ps2_data_oe}, 2'b01);
            return;
        end
        repeat (5) @(negedge clk);
        bits[0] = data_line;
        for (int k = 1; k <= 10; k++) begin
            dev_clk = 1'b0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (tx_ready) ready_seen = 1'b1;
                if (k == inject_fall && c == 1) begin
                    tx_data  = 8'h55;
                    tx_valid = 1'b1;
                end
                if (k == inject_fall && c == 2) tx_valid = 1'b0;
            end
            if (k == abort_fall) begin
                check("pre_reset_data_oe", ps2_data_oe, 1);
                #2 resetn = 1'b0;
                #1;
                check("async_clk_oe", ps2_clk_oe, 0);
                check("async_data_oe", ps2_data_oe, 0);
                dev_clk = 1'b1;
                return;
            end
            bits[k] = data_line;
            dev_clk = 1'b1;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (tx_ready) ready_seen = 1'b1;
            end
        end
        if (ack) dev_data = 1'b0;
        repeat (2) @(negedge clk);
        dev_clk = 1'b0;
        repeat (8) @(negedge clk);
        dev_clk = 1'b1;
        repeat (4) @(negedge clk);
        dev_data = 1'b1;
    endtask

    task automatic run_frame(input logic [7:0] d, input logic ack, input int inject_fall);
        int          d0, e0, i0, id0;
        bit          ok, rdy;
        logic [10:0] bits;
        exp_t        e, got;
        d0  = done_cnt;
        e0  = err_cnt;
        i0  = inh_cnt;
        id0 = inh_data_cnt;
        request(d, ok);
        if (!ok) return;
        e.bits   = frame_of(d);
        e.n_done = ack ? 1 : 0;
        e.n_err  = ack ? 0 : 1;
        sb.push_back(e);
        device_frame(ack, 0, inject_fall, bits, ok, rdy);
        if (!ok) begin
            void'(sb.pop_front());
            return;
        end
        wait_ready();
        repeat (2) @(negedge clk);
        got = sb.pop_front();
        check($sformatf("bits_%02h", d), bits, got.bits);
        check($sformatf("done_%02h", d), done_cnt - d0, got.n_done);
        check($sformatf("err_%02h", d), err_cnt - e0, got.n_err);
        check($sformatf("inhibit_len_%02h", d), inh_cnt - i0, INH);
        check($sformatf("inhibit_data_%02h", d), inh_data_cnt - id0, 1);
        check($sformatf("ready_low_%02h", d), rdy, 0);
        $display("frame %02h ack=%0d line=%03h done=%0d err=%0d", d, ack, bits,
                 done_cnt - d0, err_cnt - e0);
    endtask

    initial begin
        bit          ok, rdy;
        logic [10:0] bits;
        int          n, e0, d0;

        repeat (3) @(negedge clk);
        check("rst_ready", tx_ready, 1);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_done_err", {done, err}, 2'b00);
        $display("reset state ready=%0d clk_oe=%0d data_oe=%0d", tx_ready, ps2_clk_oe, ps2_data_oe);
        resetn = 1'b1;

        run_frame(8'hED, 1'b1, 0);
        run_frame(8'h01, 1'b1, 0);
        run_frame(8'hFF, 1'b1, 0);
        run_frame(8'h00, 1'b1, 0);
        run_frame(8'hA7, 1'b0, 0);
        run_frame(8'h3C, 1'b1, 3);

        // Device never clocks: the frame must abort on the timeout.
        e0 = err_cnt;
        d0 = done_cnt;
        request(8'h96, ok);
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < INH + 100; i++) begin
                @(negedge clk);
                if (!ps2_clk_oe && ps2_data_oe) begin
                    ok = 1'b1;
                    break;
                end
            end
            check("timeout_start", {ps2_clk_oe, ps2_data_oe}, 2'b01);
            if (ok) begin
                n = 0;
                for (int i = 0; i < 2 * TMO; i++) begin
                    @(negedge clk);
                    n++;
                    if (err) break;
                end
                check("timeout_latency", n, TMO);
                check("timeout_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
                wait_ready();
                repeat (2) @(negedge clk);
                check("timeout_err", err_cnt - e0, 1);
                check("timeout_done", done_cnt - d0, 0);
                $display("timeout frame 96 latency=%0d err=%0d", n, err_cnt - e0);
            end
        end

        // Reset asserted mid-frame at fall 5 while data is being pulled low.
        request(8'h00, ok);
        if (ok) begin
            device_frame(1'b1, 5, 0, bits, ok, rdy);
            repeat (3) @(negedge clk);
            resetn = 1'b1;
            @(posedge clk);
            #1;
            check("ready_after_reset", tx_ready, 1);
            $display("reset abort frame 00 clk_oe=%0d data_oe=%0d ready=%0d",
                     ps2_clk_oe, ps2_data_oe, tx_ready);
        end
        run_frame(8'hF4, 1'b1, 0);

        check("done_err_overlap", both_cnt, 0);
        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
